// File: rtl/dong_ho.sv
// 24-hour BCD clock core: a CLK_HZ prescaler produces a one-cycle seconds tick
// that advances six registered BCD digits (HH:MM:SS) feeding the TM1638 driver.
module dong_ho #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic       clki,
   input  logic       rs,
   output logic [3:0] led1,
   output logic [3:0] led2,
   output logic [3:0] led3,
   output logic [3:0] led4,
   output logic [3:0] led5,
   output logic [3:0] led6
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);

   logic [PW-1:0] pre_q, pre_d;
   logic          tick;

   logic [3:0] h_t_q, h_u_q, m_t_q, m_u_q, s_t_q, s_u_q;
   logic [3:0] h_t_d, h_u_d, m_t_d, m_u_d, s_t_d, s_u_d;

   assign tick  = (pre_q == PRE_LAST);
   assign pre_d = tick ? '0 : pre_q + 1'b1;

   always_comb begin
      h_t_d = h_t_q;
      h_u_d = h_u_q;
      m_t_d = m_t_q;
      m_u_d = m_u_q;
      s_t_d = s_t_q;
      s_u_d = s_u_q;
      if (tick) begin
         // Carry ripples as nested wraps so the whole chain settles on one edge.
         if (s_u_q < 4'd9) s_u_d = s_u_q + 4'd1;
         else begin
            s_u_d = 4'd0;
            if (s_t_q < 4'd5) s_t_d = s_t_q + 4'd1;
            else begin
               s_t_d = 4'd0;
               if (m_u_q < 4'd9) m_u_d = m_u_q + 4'd1;
               else begin
                  m_u_d = 4'd0;
                  if (m_t_q < 4'd5) m_t_d = m_t_q + 4'd1;
                  else begin
                     m_t_d = 4'd0;
                     if (h_t_q >= 4'd2 && h_u_q >= 4'd3) begin
                        h_t_d = 4'd0;
                        h_u_d = 4'd0;
                     end else if (h_u_q < 4'd9) h_u_d = h_u_q + 4'd1;
                     else begin
                        h_u_d = 4'd0;
                        h_t_d = h_t_q + 4'd1;
                     end
                  end
               end
            end
         end
         // A digit that was somehow driven out of range is cleared on the next tick.
         if (s_t_q > 4'd5) s_t_d = 4'd0;
         if (m_u_q > 4'd9) m_u_d = 4'd0;
         if (m_t_q > 4'd5) m_t_d = 4'd0;
         if (h_u_q > 4'd9) h_u_d = 4'd0;
         if (h_t_q > 4'd2 || h_t_d > 4'd2) begin
            h_t_d = 4'd0;
            h_u_d = 4'd0;
         end
      end
   end

   always_ff @(posedge clki or negedge rs) begin
      if (!rs) begin
         pre_q <= '0;
         h_t_q <= 4'd0;
         h_u_q <= 4'd0;
         m_t_q <= 4'd0;
         m_u_q <= 4'd0;
         s_t_q <= 4'd0;
         s_u_q <= 4'd0;
      end else begin
         pre_q <= pre_d;
         h_t_q <= h_t_d;
         h_u_q <= h_u_d;
         m_t_q <= m_t_d;
         m_u_q <= m_u_d;
         s_t_q <= s_t_d;
         s_u_q <= s_u_d;
      end
   end

   assign led1 = h_t_q;
   assign led2 = h_u_q;
   assign led3 = m_t_q;
   assign led4 = m_u_q;
   assign led5 = s_t_q;
   assign led6 = s_u_q;

endmodule

// File: tb/tb_dong_ho.sv
// Directed bench for dong_ho at CLK_HZ=4: reset hold, first ticks, carry chains,
// midnight wrap, out-of-range recovery and an asynchronous reset pulse.
`timescale 1ns/100ps
module tb_dong_ho;

   localparam int HZ = 4;

   logic       clki;
   logic       rs;
   logic [3:0] led1, led2, led3, led4, led5, led6;

   int n_cmp  = 0;
   int n_fail = 0;

   dong_ho #(.CLK_HZ(HZ)) dut (
      .clki (clki),
      .rs   (rs),
      .led1 (led1),
      .led2 (led2),
      .led3 (led3),
      .led4 (led4),
      .led5 (led5),
      .led6 (led6)
   );

   initial clki = 1'b0;
   always #10 clki = ~clki;

   // Time is compared as a packed 24-bit BCD word HH_MM_SS.
   task automatic check(input string tag, input logic [23:0] exp);
      logic [23:0] obs;
      obs = {led1, led2, led3, led4, led5, led6};
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_digit(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clki);
      #1;
   endtask

   // Preload the digit registers right after a tick edge, when the prescaler is 0.
   task automatic set_time(input logic [23:0] t);
      dut.h_t_q = t[23:20];
      dut.h_u_q = t[19:16];
      dut.m_t_q = t[15:12];
      dut.m_u_q = t[11:8];
      dut.s_t_q = t[7:4];
      dut.s_u_q = t[3:0];
   endtask

   initial begin
      rs = 1'b0;
      #1;
      check("reset_async", 24'h00_00_00);
      for (int i = 0; i < 10; i++) begin
         edges(1);
         check("reset_hold", 24'h00_00_00);
      end

      @(negedge clki);
      rs = 1'b1;
      edges(3);
      check("before_first_tick", 24'h00_00_00);
      edges(1);
      check("first_tick", 24'h00_00_01);
      edges(36);
      check("ten_ticks", 24'h00_00_10);
      edges(49 * HZ);
      check("t59", 24'h00_00_59);
      edges(HZ - 1);
      check("t59_hold", 24'h00_00_59);
      edges(1);
      check("t60", 24'h00_01_00);

      edges((3599 - 60) * HZ);
      check("t3599", 24'h00_59_59);
      edges(HZ);
      check("t3600", 24'h01_00_00);

      set_time(24'h09_59_50);
      edges(9 * HZ);
      check("t09_59_59", 24'h09_59_59);
      edges(HZ);
      check("t10_00_00", 24'h10_00_00);

      set_time(24'h19_59_59);
      edges(HZ);
      check("t20_00_00", 24'h20_00_00);

      set_time(24'h23_59_50);
      edges(9 * HZ);
      check("t23_59_59", 24'h23_59_59);
      edges(HZ);
      check("midnight_wrap", 24'h00_00_00);

      set_time(24'h00_00_0C);
      edges(HZ);
      check_digit("bad_sec_units", led6, 4'd0);

      set_time(24'h00_07_03);
      edges(HZ);
      check_digit("bad_min_tens", led3, 4'd0);
      check_digit("bad_min_tens_sec", led6, 4'd4);

      set_time(24'h12_34_56);
      edges(2);
      check("pre_reset_time", 24'h12_34_56);
      #4;
      rs = 1'b0;
      #0.5;
      check("reset_pulse_async", 24'h00_00_00);
      #0.5;
      rs = 1'b1;
      edges(3);
      check("after_pulse_3", 24'h00_00_00);
      edges(1);
      check("after_pulse_4", 24'h00_00_01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
